// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
package bus_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  // Master indices as stored in the round-robin history bit
  localparam logic M_CPU  = 1'b0;
  localparam logic M_UART = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  // Request payload presented by a master
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } bus_req_t;

endpackage

// File: rtl/bus_timeout.sv
// Per-transaction wait counter.
//   i_clk, i_reset_n : clock, async active-low reset
//   clear            : zero the counter (held while the bus is idle)
//   enable           : count this cycle (granted, requesting, no ack)
//   limit            : timeout in cycles
//   expire           : same-cycle pulse when the last allowed cycle is reached
module bus_timeout
  import bus_arb_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;

  // Wait-cycle counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expire = enable && (count_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master / one-slave arbiter for the 16-bit system bus (m0 = CPU,
// m1 = UART debug master). Serialises transactions, routes the slave ack
// to the owner and aborts a grant that waits TIMEOUT cycles for an ack.
//   i_mX_cs/we/addr/dat : master X request
//   o_mX_dat/ack/err    : master X read data, completion, timeout strobe
//   o_s_cs/we/addr/dat  : slave-side request (muxed from the owner)
//   i_s_dat/i_s_ack     : slave read data and acknowledge
//   o_grant             : one-hot owner, bit0 = m0, bit1 = m1
//   o_busy              : a grant is active
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_m0_cs,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_dat,
  output logic [DATA_W-1:0] o_m0_dat,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  input  logic              i_m1_cs,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_dat,
  output logic [DATA_W-1:0] o_m1_dat,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic              o_s_cs,
  output logic              o_s_we,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_dat,
  input  logic [DATA_W-1:0] i_s_dat,
  input  logic              i_s_ack,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  arb_state_e state_q, state_d;
  logic       last_q;
  bus_req_t   m0_req, m1_req, sel_req;
  logic       sel_cs;
  logic       in_grant;
  logic       tmo_en;
  logic       tmo_expire;

  assign m0_req = '{we: i_m0_we, addr: i_m0_addr, dat: i_m0_dat};
  assign m1_req = '{we: i_m1_we, addr: i_m1_addr, dat: i_m1_dat};

  // Read data is broadcast; each master qualifies it with its own ack
  assign o_m0_dat = i_s_dat;
  assign o_m1_dat = i_s_dat;

  assign o_grant = {state_q == GRANT1, state_q == GRANT0};
  assign o_busy  = (state_q != IDLE);

  // Only a live, unacknowledged grant consumes timeout budget
  assign tmo_en = in_grant && sel_cs && !i_s_ack;

  bus_timeout u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .clear     (state_q == IDLE),
    .enable    (tmo_en),
    .limit     (CNT_W'(TIMEOUT)),
    .expire    (tmo_expire)
  );

  // State and round-robin history registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      last_q  <= M_UART;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == GRANT0) begin
        last_q <= M_CPU;
      end else if (state_q == IDLE && state_d == GRANT1) begin
        last_q <= M_UART;
      end
    end
  end

  // Next state, owner mux and response routing
  always_comb begin
    state_d  = state_q;
    sel_cs   = 1'b0;
    sel_req  = '0;
    in_grant = 1'b0;
    o_s_cs   = 1'b0;
    o_s_we   = 1'b0;
    o_s_addr = '0;
    o_s_dat  = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_m0_cs && i_m1_cs) begin
          // Tie: UART under fixed priority, else whoever did not go last
          state_d = (FIXED_PRIO || last_q == M_CPU) ? GRANT1 : GRANT0;
        end else if (i_m0_cs) begin
          state_d = GRANT0;
        end else if (i_m1_cs) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        in_grant = 1'b1;
        sel_cs   = i_m0_cs;
        sel_req  = m0_req;
      end
      GRANT1: begin
        in_grant = 1'b1;
        sel_cs   = i_m1_cs;
        sel_req  = m1_req;
      end
      default: state_d = IDLE;
    endcase

    if (in_grant) begin
      // Expiry withdraws the request in the same cycle it is reported
      o_s_cs   = sel_cs && !tmo_expire;
      o_s_we   = sel_req.we;
      o_s_addr = sel_req.addr;
      o_s_dat  = sel_req.dat;
      if (!sel_cs || i_s_ack || tmo_expire) begin
        state_d = IDLE;
      end
      if (state_q == GRANT0) begin
        o_m0_ack = i_s_ack || tmo_expire;
        o_m0_err = tmo_expire;
      end else begin
        o_m1_ack = i_s_ack || tmo_expire;
        o_m1_err = tmo_expire;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: round-robin instance plus a
// fixed-priority instance sharing the master-side stimulus.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cs, m0_we, m1_cs, m1_we;
  logic [15:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
  logic [15:0] s_dat;
  logic        s_ack, fp_ack;

  logic [15:0] m0_rdat, m1_rdat, s_addr, s_wdat;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_cs, s_we, busy;
  logic [1:0]  grant;

  logic [15:0] fp_m0_rdat, fp_m1_rdat, fp_s_addr, fp_s_wdat;
  logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err, fp_s_cs, fp_s_we, fp_busy;
  logic [1:0]  fp_grant;

  int checks   = 0;
  int failures = 0;
  logic mon_en;

  typedef struct packed {
    logic        m;
    logic [15:0] dat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(4), .FIXED_PRIO(1'b0)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_cs(m0_cs), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_dat(m0_wdat),
    .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_cs(m1_cs), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_dat(m1_wdat),
    .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_cs(s_cs), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_dat(s_wdat),
    .i_s_dat(s_dat), .i_s_ack(s_ack), .o_grant(grant), .o_busy(busy)
  );

  bus_arbiter #(.TIMEOUT(4), .FIXED_PRIO(1'b1)) dut_fp (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_cs(m0_cs), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_dat(m0_wdat),
    .o_m0_dat(fp_m0_rdat), .o_m0_ack(fp_m0_ack), .o_m0_err(fp_m0_err),
    .i_m1_cs(m1_cs), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_dat(m1_wdat),
    .o_m1_dat(fp_m1_rdat), .o_m1_ack(fp_m1_ack), .o_m1_err(fp_m1_err),
    .o_s_cs(fp_s_cs), .o_s_we(fp_s_we), .o_s_addr(fp_s_addr), .o_s_dat(fp_s_wdat),
    .i_s_dat(s_dat), .i_s_ack(fp_ack), .o_grant(fp_grant), .o_busy(fp_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic m, input logic [15:0] d, input logic er);
    exp_t x;
    x.m   = m;
    x.dat = d;
    x.err = er;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: every ack presented by the round-robin DUT consumes one entry
  always @(negedge clk) begin
    if (rst_n && mon_en && (m0_ack || m1_ack)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", 32'({m1_ack, m0_ack}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_ack_owner", 32'({m1_ack, m0_ack}), e.m ? 32'd2 : 32'd1);
        chk("sb_err", 32'(e.m ? m1_err : m0_err), 32'(e.err));
        if (!e.err) chk("sb_rdata", 32'(e.m ? m1_rdat : m0_rdat), 32'(e.dat));
      end
    end
  end

  logic [1:0]  rr_g [3];
  logic [15:0] rr_d [3];

  initial begin
    rr_g = '{2'd1, 2'd2, 2'd1};
    rr_d = '{16'h1111, 16'h2222, 16'h3333};
    mon_en = 1'b1;
    rst_n  = 1'b0;
    m0_cs = 0; m0_we = 0; m0_addr = '0; m0_wdat = '0;
    m1_cs = 0; m1_we = 0; m1_addr = '0; m1_wdat = '0;
    s_ack = 0; fp_ack = 1'b1; s_dat = 16'h5A5A;

    // Reset state
    #3;
    chk("rst_s_cs", 32'(s_cs), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_acks", 32'({m1_ack, m0_ack, m1_err, m0_err}), 0);
    chk("rst_s_addr", 32'(s_addr), 0);
    chk("rst_m0_dat_follows", 32'(m0_rdat), 32'h5A5A);
    chk("rst_m1_dat_follows", 32'(m1_rdat), 32'h5A5A);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // m0 read at 0x1234, ack on 2nd grant cycle
    m0_cs = 1; m0_addr = 16'h1234;
    @(negedge clk);
    chk("rd_latency_idle", 32'(s_cs), 0);
    tick();
    @(negedge clk);
    chk("rd_s_cs", 32'(s_cs), 1);
    chk("rd_s_addr", 32'(s_addr), 32'h1234);
    chk("rd_grant", 32'(grant), 1);
    chk("rd_busy", 32'(busy), 1);
    tick();
    s_ack = 1; s_dat = 16'hBEEF;
    push_exp(1'b0, 16'hBEEF, 1'b0);
    @(negedge clk);
    chk("rd_m1_quiet", 32'(m1_ack), 0);
    tick();
    m0_cs = 0; s_ack = 0;
    @(negedge clk);
    chk("rd_back_idle", 32'(busy), 0);

    // Round-robin tie from reset: m0, m1, m0 with one idle cycle between
    tick();
    reset_dut();
    m0_cs = 1; m0_addr = 16'h0100;
    m1_cs = 1; m1_addr = 16'h0200;
    for (int i = 0; i < 3; i++) begin
      tick();
      s_ack = 1; s_dat = rr_d[i];
      push_exp(rr_g[i] == 2'd2, rr_d[i], 1'b0);
      @(negedge clk);
      chk("rr_grant", 32'(grant), 32'(rr_g[i]));
      chk("rr_s_addr", 32'(s_addr), (rr_g[i] == 2'd2) ? 32'h0200 : 32'h0100);
      tick();
      s_ack = 0;
      @(negedge clk);
      chk("rr_idle_gap", 32'(grant), 0);
    end
    m0_cs = 0; m1_cs = 0;

    // m1 write timeout with TIMEOUT=4
    tick();
    m1_cs = 1; m1_we = 1; m1_addr = 16'h8000; m1_wdat = 16'h00A5;
    tick();
    @(negedge clk);
    chk("to_grant", 32'(grant), 2);
    chk("to_s_cs", 32'(s_cs), 1);
    chk("to_s_we", 32'(s_we), 1);
    chk("to_s_addr", 32'(s_addr), 32'h8000);
    chk("to_s_dat", 32'(s_wdat), 32'h00A5);
    tick();
    @(negedge clk);
    chk("to_c2_no_ack", 32'({m1_ack, m1_err}), 0);
    tick();
    tick();
    push_exp(1'b1, 16'h0000, 1'b1);
    @(negedge clk);
    chk("to_s_cs_low", 32'(s_cs), 0);
    chk("to_m0_quiet", 32'({m0_ack, m0_err}), 0);
    tick();
    m1_cs = 0; m1_we = 0;
    @(negedge clk);
    chk("to_back_idle", 32'(busy), 0);

    // Ack coincides with the timeout cycle: normal completion
    m0_cs = 1; m0_addr = 16'h4444;
    tick();
    tick();
    tick();
    tick();
    s_ack = 1; s_dat = 16'hC0DE;
    push_exp(1'b0, 16'hC0DE, 1'b0);
    @(negedge clk);
    chk("coinc_s_cs", 32'(s_cs), 1);
    tick();
    s_ack = 0; m0_cs = 0;
    @(negedge clk);
    chk("coinc_back_idle", 32'(busy), 0);

    // m0 abort after one grant cycle; later ack ignored
    m0_cs = 1;
    tick();
    tick();
    m0_cs = 0;
    @(negedge clk);
    chk("abort_s_cs", 32'(s_cs), 0);
    chk("abort_no_ack", 32'({m0_ack, m0_err}), 0);
    tick();
    s_ack = 1; s_dat = 16'hDEAD;
    @(negedge clk);
    chk("abort_idle", 32'(grant), 0);
    chk("late_ack_ignored", 32'({m1_ack, m0_ack, m1_err, m0_err}), 0);
    tick();
    s_ack = 0;

    // Asynchronous reset during GRANT1, then normal service
    m1_cs = 1; m1_addr = 16'h0042;
    tick();
    @(negedge clk);
    chk("arst_pre_grant", 32'(grant), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_s_cs", 32'(s_cs), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_no_ack", 32'(m1_ack), 0);
    #1 rst_n = 1'b1;
    tick();
    s_ack = 1; s_dat = 16'h7777;
    push_exp(1'b1, 16'h7777, 1'b0);
    @(negedge clk);
    chk("arst_regrant", 32'(grant), 2);
    tick();
    s_ack = 0; m1_cs = 0;
    @(negedge clk);
    chk("arst_done_idle", 32'(busy), 0);

    // Fixed priority: m1 wins every tie, m0 starved
    mon_en = 1'b0;
    m0_cs = 1; m1_cs = 1;
    tick();
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fp_grant", 32'(fp_grant), (i % 2 == 0) ? 32'd2 : 32'd0);
      chk("fp_m1_ack", 32'(fp_m1_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("fp_m0_starved", 32'({fp_m0_ack, fp_m0_err}), 0);
    end
    m0_cs = 0; m1_cs = 0;
    tick();

    chk("sb_drain", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
